// File: rtl/diff_add_mul_pkg.sv
// Shared definitions for the difference/add/multiply pipeline.
// Mode encodings and the result formatting used by RTL and bench.
package diff_add_mul_pkg;

    localparam int RMAX = 64;

    typedef enum logic [1:0] {
        OP_DIFF_ADD = 2'b00,
        OP_DIFF_MUL = 2'b01,
        OP_ABS_ADD  = 2'b10,
        OP_ABS_MUL  = 2'b11
    } op_e;

    // Wide signed result folded to w bits by wrapping or clamping.
    function automatic logic [RMAX-1:0] sat_or_wrap(
        input logic signed [RMAX-1:0] r,
        input int                     w,
        input bit                     sat
    );
        logic [RMAX-1:0] mask;
        mask = (RMAX'(1) << w) - RMAX'(1);
        if (!sat)
            return r & mask;
        if (r < 0)
            return '0;
        if (r > $signed(mask))
            return mask;
        return r;
    endfunction

endpackage

// File: rtl/diff_add_mul_pipe_result_fifo.sv
// Show-ahead result queue; head output holds the last popped value
// while empty so downstream sees a stable vo.
module result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  last;
    logic          do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign dout   = valid ? mem[rd_ptr] : last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= mem[rd_ptr];
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/diff_add_mul_pipe.sv
// Two-stage f(i,j,k) pipeline with credit-gated input and output FIFO.
// A slot is reserved for every in-flight op, so pushes never block.
module diff_add_mul_pipe
    import diff_add_mul_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_req,
    input  logic [W-1:0] i,
    input  logic [W-1:0] j,
    input  logic [W-1:0] k,
    input  logic [1:0]   operation,
    output logic         in_valid,
    output logic [W-1:0] vo,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = 2 * W + 2;

    logic              s1_v;
    logic signed [W:0] s1_a;
    logic [W-1:0]      s1_k;
    logic              s1_mul;
    logic              s2_v;
    logic signed [RW-1:0] s2_r;

    logic [CW-1:0]     count;
    logic [CW:0]       credit;
    logic signed [W:0] d;
    logic signed [W:0] a_n;
    logic              abs_mode;
    logic              mul_mode;
    logic signed [RW-1:0] ae;
    logic signed [RW-1:0] ke;
    logic signed [RW-1:0] r_n;
    logic [W-1:0]      wdata;

    assign credit   = {1'b0, count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
    assign in_valid = in_req && !rst && (credit < (CW+1)'(DEPTH));

    assign abs_mode = (operation == OP_ABS_ADD) || (operation == OP_ABS_MUL);
    assign mul_mode = (operation == OP_DIFF_MUL) || (operation == OP_ABS_MUL);
    assign d        = $signed({1'b0, i}) - $signed({1'b0, j});
    assign a_n      = (abs_mode && d < 0) ? -d : d;

    assign ae  = {{(RW-W-1){s1_a[W]}}, s1_a};
    assign ke  = $signed({{(RW-W){1'b0}}, s1_k});
    assign r_n = s1_mul ? ae * ke : ae + ke;

    assign wdata = W'(sat_or_wrap(RMAX'(s2_r), W, SAT != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_k   <= '0;
            s1_mul <= 1'b0;
            s2_v   <= 1'b0;
            s2_r   <= '0;
        end else begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_a   <= a_n;
                s1_k   <= k;
                s1_mul <= mul_mode;
            end
            s2_v <= s1_v;
            if (s1_v)
                s2_r <= r_n;
        end
    end

    result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_v),
        .din   (wdata),
        .pop   (out_ready),
        .dout  (vo),
        .valid (out_valid),
        .count (count)
    );

endmodule

// File: tb/tb_diff_add_mul_pipe.sv
// Directed bench: wrap and saturating instances share one stimulus
// stream; results are checked against hand-computed vectors in order.
module tb_diff_add_mul_pipe;

    typedef struct {
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] k;
        logic [1:0] op;
        logic [7:0] ew;
        logic [7:0] es;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_req;
    logic [7:0] i, j, k;
    logic [1:0] operation;
    logic       out_ready;
    logic       in_valid, out_valid;
    logic [7:0] vo;
    logic       in_valid_s, out_valid_s;
    logic [7:0] vo_s;

    tv_t tbl [12];
    int  q[$];
    int  nvec = 0;
    int  nerr = 0;

    always #5 clk = ~clk;

    diff_add_mul_pipe #(.W(8), .DEPTH(4), .SAT(0)) dut (
        .clk(clk), .rst(rst), .in_req(in_req),
        .i(i), .j(j), .k(k), .operation(operation),
        .in_valid(in_valid), .vo(vo), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    diff_add_mul_pipe #(.W(8), .DEPTH(4), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .in_req(in_req),
        .i(i), .j(j), .k(k), .operation(operation),
        .in_valid(in_valid_s), .vo(vo_s), .out_valid(out_valid_s),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, got, got, exp, exp);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, then step past the edge.
    task automatic cycle(input bit req, input int v, input bit rdy,
                         output bit acc, output bit pop);
        int idx;
        in_req    = req;
        i         = tbl[v].i;
        j         = tbl[v].j;
        k         = tbl[v].k;
        operation = tbl[v].op;
        out_ready = rdy;
        #1;
        acc = in_valid && req;
        pop = out_valid && rdy;
        if (acc)
            chk("sat_accept", int'(in_valid_s), 1);
        if (pop) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL spurious_result: got vo 0x%0h, expected none", vo);
            end else begin
                idx = q.pop_front();
                chk("vo_wrap", int'(vo), int'(tbl[idx].ew));
                chk("sat_valid", int'(out_valid_s), 1);
                chk("vo_sat", int'(vo_s), int'(tbl[idx].es));
            end
        end
        if (acc)
            q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc, pop;
        int lat, cnt, pops;
        bit got;

        tbl[0]  = '{8'd10,  8'd3,   8'd5,   2'b00, 8'h0C, 8'h0C};
        tbl[1]  = '{8'd3,   8'd10,  8'd5,   2'b01, 8'hDD, 8'h00};
        tbl[2]  = '{8'd3,   8'd10,  8'd5,   2'b10, 8'h0C, 8'h0C};
        tbl[3]  = '{8'd3,   8'd10,  8'd5,   2'b11, 8'h23, 8'h23};
        tbl[4]  = '{8'd200, 8'd0,   8'd200, 2'b01, 8'h40, 8'hFF};
        tbl[5]  = '{8'd0,   8'd50,  8'd10,  2'b00, 8'hD8, 8'h00};
        tbl[6]  = '{8'd255, 8'd0,   8'd255, 2'b00, 8'hFE, 8'hFF};
        tbl[7]  = '{8'd0,   8'd255, 8'd255, 2'b11, 8'h01, 8'hFF};
        tbl[8]  = '{8'd0,   8'd255, 8'd0,   2'b01, 8'h00, 8'h00};
        tbl[9]  = '{8'd0,   8'd255, 8'd3,   2'b01, 8'h03, 8'h00};
        tbl[10] = '{8'd100, 8'd100, 8'd7,   2'b10, 8'h07, 8'h07};
        tbl[11] = '{8'd128, 8'd1,   8'd2,   2'b01, 8'hFE, 8'hFE};

        rst = 1'b1;
        in_req = 1'b1;
        i = 8'd1; j = 8'd2; k = 8'd3;
        operation = 2'b00;
        out_ready = 1'b1;

        // Reset held for two cycles with a pending request.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_in_valid", int'(in_valid), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_vo", int'(vo), 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_valid", int'(in_valid), 1);
        in_req = 1'b0;
        @(posedge clk);
        #1;

        // Isolated vectors: latency and value of each mode.
        for (int v = 0; v < 12; v++) begin
            cycle(1'b1, v, 1'b1, acc, pop);
            chk("single_accept", int'(acc), 1);
            lat = 0;
            got = 1'b0;
            for (int n = 1; n <= 6 && !got; n++) begin
                cycle(1'b0, 0, 1'b1, acc, pop);
                if (pop) begin
                    got = 1'b1;
                    lat = n;
                end
            end
            chk("latency", lat, 3);
        end
        chk("empty_out_valid", int'(out_valid), 0);
        chk("vo_hold", int'(vo), int'(tbl[11].ew));

        // Back-to-back stream with the consumer always ready.
        pops = 0;
        for (int v = 0; v < 8; v++) begin
            cycle(1'b1, v, 1'b1, acc, pop);
            chk("stream_accept", int'(acc), 1);
            pops += int'(pop);
        end
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, 0, 1'b1, acc, pop);
            pops += int'(pop);
        end
        chk("stream_pops", pops, 8);
        chk("stream_queue", q.size(), 0);

        // Backpressure: credits cap acceptance at DEPTH.
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            cycle(1'b1, n + 2, 1'b0, acc, pop);
            cnt += int'(acc);
        end
        chk("bp_accepts", cnt, 4);
        chk("bp_full_in_valid", int'(acc), 0);
        cycle(1'b1, 4, 1'b1, acc, pop);
        chk("bp_pop_cycle_accept", int'(acc), 0);
        chk("bp_pop", int'(pop), 1);
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, 5, 1'b0, acc, pop);
            cnt += int'(acc);
        end
        chk("bp_refill", cnt, 1);
        pops = 0;
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, 0, 1'b1, acc, pop);
            pops += int'(pop);
        end
        chk("bp_drain", pops, 4);
        chk("bp_queue", q.size(), 0);

        // Reset with two queued and two in flight.
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, n + 6, 1'b0, acc, pop);
            cnt += int'(acc);
        end
        chk("mid_accepts", cnt, 4);
        chk("mid_pre_out_valid", int'(out_valid), 1);
        in_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_valid", int'(in_valid), 0);
        chk("mid_rst_vo", int'(vo), 0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        cycle(1'b1, 9, 1'b1, acc, pop);
        chk("post_mid_accept", int'(acc), 1);
        lat = 0;
        got = 1'b0;
        for (int n = 1; n <= 8 && !got; n++) begin
            cycle(1'b0, 0, 1'b1, acc, pop);
            if (pop) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk("post_mid_latency", lat, 3);
        chk("post_mid_queue", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
